axis_pkt_decouple_ctrl: RTL

//  Packet-boundary-aware decouple controller for N_ID AXI4S streams; sits directly upstream of axis_decoupler.

---
 rtl/axis_pkt_decouple_ctrl_pkg.sv | 6 +
 rtl/axis_pkt_decouple_lane.sv | 56 +++++
 rtl/axis_pkt_decouple_ctrl.sv | 40 ++++
 3 files changed

// File: rtl/axis_pkt_decouple_ctrl_pkg.sv
// axis_pkt_decouple_ctrl_pkg: shared defaults and lane state type for the packet-aware decouple controller
package axis_pkt_decouple_ctrl_pkg;
  localparam int AXI_DATA_BITS = 64;
  localparam int N_REGIONS = 2;
  typedef enum logic [1:0] {ST_ACTIVE, ST_DRAIN, ST_DECOUPLED} pkt_dcpl_state_t;
endpackage

// File: rtl/axis_pkt_decouple_lane.sv
// axis_pkt_decouple_lane: one-lane packet-aware decouple FSM; DECOUPLE_TIMEOUT_EN adds a forced-decouple drain timeout
module axis_pkt_decouple_lane import axis_pkt_decouple_ctrl_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic aclk,
  input  logic areset,
  input  logic req,
  input  logic s_tvalid,
  input  logic s_tlast,
  input  logic m_tready,
  output logic s_tready,
  output logic m_tvalid,
  output logic ack,
  output logic timeout_flag
);
  pkt_dcpl_state_t state, next_state;
  logic in_pkt, pass, hs, done, expire;
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 2");
  end
  assign pass = state == ST_ACTIVE || (state == ST_DRAIN && in_pkt);
  assign m_tvalid = s_tvalid & pass;
  assign s_tready = m_tready & pass;
  assign hs = s_tvalid & m_tready & pass;
  assign done = !in_pkt || (hs && s_tlast);
`ifdef DECOUPLE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt;
  assign expire = state == ST_DRAIN && cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge aclk)
    if (areset) begin
      cnt <= '0;
      timeout_flag <= 1'b0;
    end else begin
      cnt <= state == ST_DRAIN ? cnt + 1'b1 : '0;
      timeout_flag <= req & (timeout_flag | (expire & !done));
    end
`else
  assign expire = 1'b0;
  assign timeout_flag = 1'b0;
`endif
  always_comb
    next_state = state == ST_ACTIVE ? (req ? ST_DRAIN : ST_ACTIVE) :
                 !req ? ST_ACTIVE :
                 (state == ST_DECOUPLED || done || expire) ? ST_DECOUPLED : ST_DRAIN;
  always_ff @(posedge aclk)
    if (areset) begin
      state <= ST_ACTIVE;
      in_pkt <= 1'b0;
      ack <= 1'b0;
    end else begin
      state <= next_state;
      in_pkt <= (hs ? !s_tlast : in_pkt) & !(expire & req);
      ack <= next_state == ST_DECOUPLED;
    end
endmodule

// File: rtl/axis_pkt_decouple_ctrl.sv
// axis_pkt_decouple_ctrl: per-lane packet-boundary-aware AXI4S decouple gate; DECOUPLE_TIMEOUT_EN enables drain timeout
module axis_pkt_decouple_ctrl import axis_pkt_decouple_ctrl_pkg::*; #(
  parameter int DATA_BITS = AXI_DATA_BITS,
  parameter int N_ID = N_REGIONS,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [N_ID-1:0]            decouple_req,
  output logic [N_ID-1:0]            decouple_ack,
  output logic [N_ID-1:0]            timeout_flag,
  input  logic [N_ID-1:0]            s_axis_tvalid,
  output logic [N_ID-1:0]            s_axis_tready,
  input  logic [N_ID*DATA_BITS-1:0]  s_axis_tdata,
  input  logic [N_ID*DATA_BITS/8-1:0] s_axis_tkeep,
  input  logic [N_ID-1:0]            s_axis_tlast,
  output logic [N_ID-1:0]            m_axis_tvalid,
  input  logic [N_ID-1:0]            m_axis_tready,
  output logic [N_ID*DATA_BITS-1:0]  m_axis_tdata,
  output logic [N_ID*DATA_BITS/8-1:0] m_axis_tkeep,
  output logic [N_ID-1:0]            m_axis_tlast
);
  assign m_axis_tdata = s_axis_tdata;
  assign m_axis_tkeep = s_axis_tkeep;
  assign m_axis_tlast = s_axis_tlast;
  for (genvar i = 0; i < N_ID; i++) begin : g_lane
    axis_pkt_decouple_lane #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_lane (
      .aclk(aclk),
      .areset(areset),
      .req(decouple_req[i]),
      .s_tvalid(s_axis_tvalid[i]),
      .s_tlast(s_axis_tlast[i]),
      .m_tready(m_axis_tready[i]),
      .s_tready(s_axis_tready[i]),
      .m_tvalid(m_axis_tvalid[i]),
      .ack(decouple_ack[i]),
      .timeout_flag(timeout_flag[i])
    );
  end
endmodule
